// File: rtl/cnn_pkg.sv
// ============================================================================
// Module      : cnn_pkg
// Description : Shared CNN datapath constants, width helpers and index type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_pkg;

    localparam int c_DATA_WIDTH         = 8;
    localparam int c_WEIGHT_WIDTH       = 8;
    localparam int c_KERNEL_ROW_SIZE    = 3;
    localparam int c_KERNEL_COLUMN_SIZE = 3;
    localparam int c_OUT_WIDTH          = 8;

    function automatic int prod_width(input int data_w, input int weight_w);
        return data_w + weight_w + 1;
    endfunction

    // Headroom for the sum of all taps plus bias.
    function automatic int acc_width(input int data_w, input int weight_w, input int taps);
        return data_w + weight_w + 2 + $clog2(taps);
    endfunction

    localparam int c_TAPS       = c_KERNEL_ROW_SIZE * c_KERNEL_COLUMN_SIZE;
    localparam int c_PROD_WIDTH = prod_width(c_DATA_WIDTH, c_WEIGHT_WIDTH);
    localparam int c_ACC_WIDTH  = acc_width(c_DATA_WIDTH, c_WEIGHT_WIDTH, c_TAPS);

    typedef logic [$clog2(c_TAPS+1)-1:0] w_index_t;

endpackage

`default_nettype wire

// File: rtl/conv_adder_tree.sv
// ============================================================================
// Module      : conv_adder_tree
// Description : Combinational signed reduction of N_TERMS values (heap tree).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_adder_tree #(
    parameter int N_TERMS   = 9,
    parameter int IN_WIDTH  = 17,
    parameter int OUT_WIDTH = 22
) (
    input  logic signed [IN_WIDTH-1:0]  i_terms [N_TERMS],
    output logic signed [OUT_WIDTH-1:0] o_sum
);

    // Leaves at N_TERMS-1..2*N_TERMS-2; node k sums children 2k+1 and 2k+2.
    logic signed [OUT_WIDTH-1:0] w_node [2*N_TERMS-1];

    always_comb begin
        for (int k = 0; k < N_TERMS; k++) begin
            w_node[N_TERMS-1+k] = {{(OUT_WIDTH-IN_WIDTH){i_terms[k][IN_WIDTH-1]}}, i_terms[k]};
        end
        for (int k = N_TERMS-2; k >= 0; k--) begin
            w_node[k] = w_node[2*k+1] + w_node[2*k+2];
        end
        o_sum = w_node[0];
    end

endmodule

`default_nettype wire

// File: rtl/conv_kernel_mac.sv
// ============================================================================
// Module      : conv_kernel_mac
// Description : KxK window multiply-accumulate with bias, shift, ReLU, saturate.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_kernel_mac
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int WEIGHT_WIDTH       = 8,
    parameter int KERNEL_ROW_SIZE    = 3,
    parameter int KERNEL_COLUMN_SIZE = 3,
    parameter int OUT_WIDTH          = 8,
    parameter int OUT_SHIFT          = 0
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic [DATA_WIDTH*KERNEL_ROW_SIZE*KERNEL_COLUMN_SIZE-1:0] in_matrix,
    input  logic                                                   valid_in,
    input  logic                                                   relu_en,
    input  logic                                                   w_load,
    input  logic [$clog2(KERNEL_ROW_SIZE*KERNEL_COLUMN_SIZE+1)-1:0] w_index,
    input  logic [WEIGHT_WIDTH-1:0]                                w_data,
    input  logic                                                   w_clear,
    output logic                                                   weights_ready,
    output logic [OUT_WIDTH-1:0]                                   out_pixel,
    output logic                                                   valid_out,
    output logic                                                   sat_flag
);

    localparam int c_N_TAPS = KERNEL_ROW_SIZE * KERNEL_COLUMN_SIZE;
    localparam int c_IDX_W  = $clog2(c_N_TAPS + 1);
    localparam int c_PROD_W = prod_width(DATA_WIDTH, WEIGHT_WIDTH);
    localparam int c_ACC_W  = acc_width(DATA_WIDTH, WEIGHT_WIDTH, c_N_TAPS);

    localparam logic signed [c_ACC_W-1:0] c_OUT_MAX =
        {{(c_ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [c_ACC_W-1:0] c_OUT_MIN =
        {{(c_ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [WEIGHT_WIDTH-1:0] r_weights [c_N_TAPS];
    logic signed [WEIGHT_WIDTH-1:0] r_bias;
    logic [c_N_TAPS:0]              r_loaded;
    logic [c_N_TAPS:0]              w_loaded_next;

    always_comb begin
        w_loaded_next = r_loaded;
        if (w_clear) begin
            w_loaded_next = '0;
        end else if (w_load) begin
            for (int k = 0; k <= c_N_TAPS; k++) begin
                if (w_index == c_IDX_W'(k)) w_loaded_next[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < c_N_TAPS; k++) r_weights[k] <= '0;
            r_bias        <= '0;
            r_loaded      <= '0;
            weights_ready <= 1'b0;
        end else begin
            r_loaded      <= w_loaded_next;
            weights_ready <= &w_loaded_next;
            if (w_clear) begin
                for (int k = 0; k < c_N_TAPS; k++) r_weights[k] <= '0;
                r_bias <= '0;
            end else if (w_load) begin
                for (int k = 0; k < c_N_TAPS; k++) begin
                    if (w_index == c_IDX_W'(k)) r_weights[k] <= w_data;
                end
                if (w_index == c_IDX_W'(c_N_TAPS)) r_bias <= w_data;
            end
        end
    end

    // S1: products use the coefficient values in place before this edge.
    logic                        w_accept;
    logic signed [c_PROD_W-1:0]  w_px_ext [c_N_TAPS];
    logic signed [c_PROD_W-1:0]  w_wt_ext [c_N_TAPS];
    logic signed [c_PROD_W-1:0]  r_prod   [c_N_TAPS];
    logic signed [WEIGHT_WIDTH-1:0] r_bias1;
    logic                        r_v1, r_relu1;

    assign w_accept = valid_in && weights_ready;

    always_comb begin
        for (int k = 0; k < c_N_TAPS; k++) begin
            w_px_ext[k] = {{(c_PROD_W-DATA_WIDTH){1'b0}}, in_matrix[DATA_WIDTH*k +: DATA_WIDTH]};
            w_wt_ext[k] = {{(c_PROD_W-WEIGHT_WIDTH){r_weights[k][WEIGHT_WIDTH-1]}}, r_weights[k]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < c_N_TAPS; k++) r_prod[k] <= '0;
            r_bias1 <= '0;
            r_v1    <= 1'b0;
            r_relu1 <= 1'b0;
        end else begin
            r_v1 <= w_accept;
            if (w_accept) begin
                for (int k = 0; k < c_N_TAPS; k++) r_prod[k] <= w_px_ext[k] * w_wt_ext[k];
                r_bias1 <= r_bias;
                r_relu1 <= relu_en;
            end
        end
    end

    // S2: accumulate.
    logic signed [c_ACC_W-1:0] w_tree_sum;
    logic signed [c_ACC_W-1:0] w_bias_ext;
    logic signed [c_ACC_W-1:0] r_acc;
    logic                      r_v2, r_relu2;

    conv_adder_tree #(
        .N_TERMS   (c_N_TAPS),
        .IN_WIDTH  (c_PROD_W),
        .OUT_WIDTH (c_ACC_W)
    ) u_adder_tree (
        .i_terms (r_prod),
        .o_sum   (w_tree_sum)
    );

    assign w_bias_ext = {{(c_ACC_W-WEIGHT_WIDTH){r_bias1[WEIGHT_WIDTH-1]}}, r_bias1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_v2    <= 1'b0;
            r_relu2 <= 1'b0;
        end else begin
            r_acc   <= w_tree_sum + w_bias_ext;
            r_v2    <= r_v1;
            r_relu2 <= r_relu1;
        end
    end

    // S3: floor shift.
    logic signed [c_ACC_W-1:0] r_sh;
    logic                      r_v3, r_relu3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh    <= '0;
            r_v3    <= 1'b0;
            r_relu3 <= 1'b0;
        end else begin
            r_sh    <= r_acc >>> OUT_SHIFT;
            r_v3    <= r_v2;
            r_relu3 <= r_relu2;
        end
    end

    logic [OUT_WIDTH-1:0] w_out_next;
    logic                 w_sat_next;

    // ReLU zeroing of a negative value is not a saturation event.
    always_comb begin
        w_out_next = r_sh[OUT_WIDTH-1:0];
        w_sat_next = 1'b0;
        if (r_relu3 && (r_sh < 0)) begin
            w_out_next = '0;
        end else if (r_sh > c_OUT_MAX) begin
            w_out_next = c_OUT_MAX[OUT_WIDTH-1:0];
            w_sat_next = 1'b1;
        end else if (!r_relu3 && (r_sh < c_OUT_MIN)) begin
            w_out_next = c_OUT_MIN[OUT_WIDTH-1:0];
            w_sat_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            out_pixel <= '0;
            sat_flag  <= 1'b0;
        end else begin
            valid_out <= r_v3;
            if (r_v3) begin
                out_pixel <= w_out_next;
                sat_flag  <= w_sat_next;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_conv_kernel_mac.sv
// ============================================================================
// Module      : tb_conv_kernel_mac
// Description : Scoreboard bench for conv_kernel_mac against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_kernel_mac;

    localparam int DW = 8;
    localparam int WW = 8;
    localparam int OW = 8;
    localparam int SH = 0;
    localparam int N  = 9;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW*N-1:0] in_matrix;
    logic            valid_in, relu_en, w_load, w_clear;
    logic [IW-1:0]   w_index;
    logic [WW-1:0]   w_data;
    logic            weights_ready, valid_out, sat_flag;
    logic [OW-1:0]   out_pixel;

    conv_kernel_mac #(
        .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .KERNEL_ROW_SIZE(3),
        .KERNEL_COLUMN_SIZE(3), .OUT_WIDTH(OW), .OUT_SHIFT(SH)
    ) dut (
        .clk(clk), .rst(rst), .in_matrix(in_matrix), .valid_in(valid_in),
        .relu_en(relu_en), .w_load(w_load), .w_index(w_index), .w_data(w_data),
        .w_clear(w_clear), .weights_ready(weights_ready), .out_pixel(out_pixel),
        .valid_out(valid_out), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pix;
        bit sat;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   m_w[N];
    int   m_b;
    bit   m_mask[N+1];
    bit   m_ready;
    int   px[N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic void model_clear();
        for (int k = 0; k < N; k++) m_w[k] = 0;
        m_b = 0;
        for (int k = 0; k <= N; k++) m_mask[k] = 1'b0;
        m_ready = 1'b0;
    endfunction

    // Reference result of the window currently on the input pins.
    function automatic exp_t ref_model();
        exp_t e;
        int   acc = m_b;
        int   sh;
        for (int k = 0; k < N; k++) acc += int'(in_matrix[DW*k +: DW]) * m_w[k];
        sh    = acc >>> SH;
        e.sat = 1'b0;
        if (relu_en && sh < 0) e.pix = 0;
        else if (sh > 127) begin e.pix = 127; e.sat = 1'b1; end
        else if (!relu_en && sh < -128) begin e.pix = -128; e.sat = 1'b1; end
        else e.pix = sh;
        e.cyc = 0;
        return e;
    endfunction

    task automatic tick();
        exp_t e;
        if (valid_in && m_ready) begin
            e     = ref_model();
            e.cyc = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk);
        if (w_clear) begin
            model_clear();
        end else if (w_load && int'(w_index) <= N) begin
            if (int'(w_index) < N) m_w[w_index] = int'($signed(w_data));
            else m_b = int'($signed(w_data));
            m_mask[w_index] = 1'b1;
        end
        m_ready = 1'b1;
        for (int k = 0; k <= N; k++) if (!m_mask[k]) m_ready = 1'b0;
        #1;
        valid_in = 1'b0;
        w_load   = 1'b0;
        w_clear  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic load(input int idx, input int data);
        w_load  = 1'b1;
        w_index = IW'(idx);
        w_data  = WW'(data);
        tick();
    endtask

    task automatic load_all(input int wv, input int bv);
        for (int k = 0; k < N; k++) load(k, wv);
        load(N, bv);
    endtask

    // Presents px[] as a window; any weight write set up by the caller shares the edge.
    task automatic send(input bit relu);
        for (int k = 0; k < N; k++) in_matrix[DW*k +: DW] = DW'(px[k]);
        relu_en  = relu;
        valid_in = 1'b1;
        tick();
    endtask

    task automatic seq_window();
        for (int k = 0; k < N; k++) px[k] = k + 1;
    endtask

    // Monitor: valid_out must appear exactly 3 edges after each accepted window.
    exp_t m_e;
    bit   m_ev;
    always @(negedge clk) begin
        check("weights_ready", int'(weights_ready), int'(m_ready));
        m_ev = (q.size() > 0) && (q[0].cyc + 3 == cyc);
        check("valid_out", int'(valid_out), int'(m_ev));
        if (m_ev && !valid_out) begin
            void'(q.pop_front());
        end else if (valid_out && q.size() > 0) begin
            m_e = q.pop_front();
            check("out_pixel", int'($signed(out_pixel)), m_e.pix);
            check("sat_flag", int'(sat_flag), int'(m_e.sat));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; valid_in = 1'b0; relu_en = 1'b0; w_load = 1'b0;
        w_clear = 1'b0; w_index = '0; w_data = '0; in_matrix = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_pixel", int'(out_pixel), 0);
        check("reset_valid_out", int'(valid_out), 0);
        check("reset_sat_flag", int'(sat_flag), 0);
        check("reset_weights_ready", int'(weights_ready), 0);
        rst = 1'b0;
        idle(2);

        // Identity weights: 1..9 sums to 45; saturation both ways.
        load_all(1, 0);
        seq_window(); send(1'b0);
        for (int k = 0; k < N; k++) px[k] = 255;
        send(1'b0);
        idle(4);
        load_all(-1, 0);
        send(1'b0);
        seq_window();
        send(1'b0); send(1'b1); send(1'b0); send(1'b1);
        idle(5);

        // Partial load keeps the engine idle; bias completes it.
        w_clear = 1'b1; tick();
        for (int k = 0; k < N; k++) load(k, 1);
        seq_window(); send(1'b0);
        load(N, 5);
        send(1'b0);
        load(15, 99);
        send(1'b0);
        idle(5);

        // Frame stream with random coefficients and a mid-stream weight rewrite.
        for (int k = 0; k < N; k++) load(k, int'($urandom_range(0, 255)) - 128);
        load(N, int'($urandom_range(0, 255)) - 128);
        for (int n = 0; n < 36; n++) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    px[i*3+j] = ((n/6 + i) % 6) * 6 + ((n%6 + j) % 6) + 1;
            if (n == 18) begin
                w_load = 1'b1; w_index = IW'(4); w_data = WW'(2);
            end
            send(1'($urandom_range(0, 1)));
        end
        idle(5);

        // Random traffic with interleaved writes and occasional clears.
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < N; k++) px[k] = int'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) begin
                w_load  = 1'b1;
                w_index = IW'($urandom_range(0, 15));
                w_data  = WW'($urandom);
            end
            if ($urandom_range(0, 63) == 0) w_clear = 1'b1;
            if ($urandom_range(0, 3) != 0) send(1'($urandom_range(0, 1)));
            else tick();
        end
        idle(5);

        // Asynchronous reset with windows in flight.
        load_all(3, -7);
        seq_window();
        repeat (4) send(1'b0);
        check("valid_out_before_rst", int'(valid_out), 1);
        #1;
        rst = 1'b1;
        q.delete();
        model_clear();
        #1;
        check("rst_async_valid_out", int'(valid_out), 0);
        check("rst_async_weights_ready", int'(weights_ready), 0);
        check("rst_async_out_pixel", int'(out_pixel), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        idle(6);

        // Clear mid-stream: the window on the clear edge still completes.
        load_all(2, 1);
        for (int n = 0; n < 6; n++) begin
            for (int k = 0; k < N; k++) px[k] = int'($urandom_range(0, 40));
            if (n == 3) w_clear = 1'b1;
            send(1'b0);
        end
        idle(8);

        check("scoreboard_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
